// File: rtl/bcd2bin_pkg.sv
// Shared types and sizing helpers for the bcd2bin converter.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = $clog2(2 * N_DEF + 1);

  // Enough BCD digits to represent any 2n-bit value.
  function automatic int bcd_digits(input int n);
    return (2 * n) / 3 + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit cell: a digit of 8 or more after the shift
// absorbed a borrowed half-ten, so pull it back by 3.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Conditional subtract-3 correction
  always_comb begin
    adj = digit;
    if (digit >= 4'd8) begin
      adj = digit - 4'd3;
    end else begin
      adj = digit;
    end
  end

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble, 2N iterations).
// Optional invalid-digit check compiled in with BCD2BIN_CHECK_EN.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter  int N  = 8,
  localparam int D  = bcd_digits(N),
  localparam int BW = 2 * N,
  localparam int DW = 4 * D,
  localparam int RW = DW + BW,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] bcd_in,
  output logic [BW-1:0] out,
  output logic          finish,
  output logic          busy,
  output logic          ovf,
  output logic          err
);

  state_e        state_r;
  logic [RW-1:0] w_r;
  logic [CW-1:0] count_r;
  logic [RW-1:0] shift_s;
  logic [DW-1:0] digits_next_s;
  logic [RW-1:0] w_next_s;
  logic          bad_s;

`ifdef BCD2BIN_CHECK_EN
  function automatic logic has_bad_digit(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign bad_s = has_bad_digit(bcd_in);
`else
  assign bad_s = 1'b0;
`endif

  assign shift_s = {1'b0, w_r[RW-1:1]};

  for (genvar gi = 0; gi < D; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (shift_s[BW + 4*gi +: 4]),
      .adj   (digits_next_s[4*gi +: 4])
    );
  end

  assign w_next_s = {digits_next_s, shift_s[BW-1:0]};

  // Control FSM, working register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      w_r     <= '0;
      count_r <= '0;
      out     <= '0;
      finish  <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (bad_s) begin
              // Rejected operand completes immediately with a zero result.
              w_r     <= '0;
              count_r <= '0;
              out     <= '0;
              ovf     <= 1'b0;
              err     <= 1'b1;
              finish  <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              w_r     <= {bcd_in, {BW{1'b0}}};
              count_r <= CW'(BW);
              ovf     <= 1'b0;
              err     <= 1'b0;
              finish  <= 1'b0;
              busy    <= 1'b1;
              state_r <= ST_SHIFT;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT: begin
          w_r     <= w_next_s;
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            // Any residue left in the digit field means the value overflowed 2N bits.
            out     <= w_next_s[BW-1:0];
            ovf     <= |w_next_s[RW-1:BW];
            finish  <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          finish  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Directed-vector bench for bcd2bin (N=8); adapts the invalid-digit vector to
// whether BCD2BIN_CHECK_EN is defined.
module tb_bcd2bin;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] bcd_in;
  logic [15:0] out;
  logic        finish;
  logic        busy;
  logic        ovf;
  logic        err;

  int n_vec;
  int n_miss;

  bcd2bin #(.N(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd_in (bcd_in),
    .out    (out),
    .finish (finish),
    .busy   (busy),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start one conversion; lat = edges after capture until finish, bcnt = busy samples.
  task automatic run_conv(input logic [23:0] bcd, output int lat, output int bcnt);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!finish && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv_check(input string tag, input logic [23:0] bcd,
                            input logic [15:0] exp_out, input logic exp_ovf);
    int lat, bcnt;
    run_conv(bcd, lat, bcnt);
    check_val({tag, "_lat"}, lat, 16);
    check_val({tag, "_out"}, {16'd0, out}, {16'd0, exp_out});
    check_val({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    int lat, bcnt, hi, lo;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    start  = 1'b0;
    bcd_in = 24'h0;
    repeat (2) @(negedge clk);
    check_val("rst_out",    {16'd0, out},    32'd0);
    check_val("rst_finish", {31'd0, finish}, 32'd0);
    check_val("rst_busy",   {31'd0, busy},   32'd0);
    check_val("rst_ovf",    {31'd0, ovf},    32'd0);
    check_val("rst_err",    {31'd0, err},    32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_conv(24'h012345, lat, bcnt);
    check_val("c12345_lat",  lat, 16);
    check_val("c12345_busy", bcnt, 16);
    check_val("c12345_out",  {16'd0, out}, 32'h3039);
    check_val("c12345_ovf",  {31'd0, ovf}, 32'd0);
    check_val("c12345_bsyoff", {31'd0, busy}, 32'd0);
    check_val("c12345_err",  {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("hold_out",    {16'd0, out}, 32'h3039);
    check_val("hold_finish", {31'd0, finish}, 32'd1);

    conv_check("c65535", 24'h065535, 16'hFFFF, 1'b0);
    conv_check("c65536", 24'h065536, 16'h0000, 1'b1);
    conv_check("c999999", 24'h999999, 16'h423F, 1'b1);
    conv_check("c0", 24'h000000, 16'h0000, 1'b0);

    // start held high: back-to-back conversions of 123 = 0x7B
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 24'h000123;
    @(negedge clk);
    lat = 0;
    while (!finish && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("bb_first_lat", lat, 16);
    for (int p = 0; p < 2; p++) begin
      check_val("bb_out", {16'd0, out}, 32'h7B);
      hi = 0;
      while (finish && hi < 40) begin
        @(negedge clk);
        hi++;
      end
      lo = 0;
      while (!finish && lo < 40) begin
        @(negedge clk);
        lo++;
      end
      check_val("bb_fin_hi", hi, 1);
      check_val("bb_period", hi + lo, 17);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // start pulse mid-conversion is ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 24'h000042;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bcd_in = 24'h000999;
    @(negedge clk);
    start = 1'b0;
    lat = 5;
    while (!finish && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("ign_lat", lat, 16);
    check_val("ign_out", {16'd0, out}, 32'h2A);

    // reset in the middle of iteration 7
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 24'h000777;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("mrst_out",    {16'd0, out},    32'd0);
    check_val("mrst_finish", {31'd0, finish}, 32'd0);
    check_val("mrst_busy",   {31'd0, busy},   32'd0);
    check_val("mrst_ovf",    {31'd0, ovf},    32'd0);
    @(negedge clk);
    reset = 1'b1;
    conv_check("c100", 24'h000100, 16'h0064, 1'b0);

    // invalid digit A
    run_conv(24'h00A123, lat, bcnt);
`ifdef BCD2BIN_CHECK_EN
    check_val("bad_lat", lat, 0);
    check_val("bad_err", {31'd0, err}, 32'd1);
    check_val("bad_out", {16'd0, out}, 32'd0);
    check_val("bad_fin", {31'd0, finish}, 32'd1);
`else
    check_val("bad_lat", lat, 16);
    check_val("bad_err", {31'd0, err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
